alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_comb.sv | 44 ++++
 rtl/alu_exec.sv | 97 +++++++++
 tb/tb_alu_exec.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width default, op codes and FSM states for the ALU execution unit
package alu_pkg;

   localparam int WIDTH_DEF = 16;

   // Op codes 4'hD..4'hF are reserved and intentionally absent from the enum
   typedef enum logic [3:0] {
      OP_ROL  = 4'h0,
      OP_SLL  = 4'h1,
      OP_ROR  = 4'h2,
      OP_SRL  = 4'h3,
      OP_ADD  = 4'h4,
      OP_SUB  = 4'h5,
      OP_XOR  = 4'h6,
      OP_ANDN = 4'h7,
      OP_SEQ  = 4'h8,
      OP_SLT  = 4'h9,
      OP_SLE  = 4'hA,
      OP_SCO  = 4'hB,
      OP_BTR  = 4'hC
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Shift and rotate ops occupy codes 0..3
   function automatic logic is_shift(input logic [3:0] op);
      return (op[3:2] == 2'b00);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle combinational ALU ops
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] rev;

   assign sum_ext = {1'b0, a} + {1'b0, b};

   // Bit-reverse of operand A
   always_comb begin
      rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev[i] = a[WIDTH-1-i];
      end
   end

   // Op decode; shift ops only reach here with a zero amount, so they pass A through
   always_comb begin
      value = '0;
      case (op)
         OP_ROL, OP_SLL, OP_ROR, OP_SRL: value = a;
         OP_ADD:  value = sum_ext[WIDTH-1:0];
         OP_SUB:  value = b - a;
         OP_XOR:  value = a ^ b;
         OP_ANDN: value = a & ~b;
         OP_SEQ:  value = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_SLT:  value = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLE:  value = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
         OP_SCO:  value = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
         OP_BTR:  value = rev;
         default: value = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - ALU execution unit with iterative shifter and valid/ready handshake
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   state_e           state;
   logic [3:0]       cnt;
   logic [3:0]       shift_op;
   logic [WIDTH-1:0] comb_value;
   logic [WIDTH-1:0] step_value;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .op    (op),
      .a     (a),
      .b     (b),
      .value (comb_value)
   );

   // Gated by rst_n so the unit never advertises readiness while held in reset
   assign in_ready = rst_n && (state == ST_IDLE);

   // One-bit step of the iterative shifter, working on the partial result
   always_comb begin
      step_value = result;
      case (shift_op)
         OP_ROL:  step_value = {result[WIDTH-2:0], result[WIDTH-1]};
         OP_SLL:  step_value = {result[WIDTH-2:0], 1'b0};
         OP_ROR:  step_value = {result[0], result[WIDTH-1:1]};
         default: step_value = {1'b0, result[WIDTH-1:1]};
      endcase
   end

   // Control FSM, shift counter and output register; flush overrides everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         result    <= '0;
         cnt       <= '0;
         shift_op  <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (is_shift(op) && (b[3:0] != 4'd0)) begin
                     state    <= ST_BUSY;
                     result   <= a;
                     cnt      <= b[3:0];
                     shift_op <= op;
                  end else begin
                     state     <= ST_DONE;
                     result    <= comb_value;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               result <= step_value;
               cnt    <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard testbench for alu_exec
module tb_alu_exec;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;

   typedef struct {
      string        tag;
      logic [W-1:0] res;
      int           wt;
      int           acc;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int handshakes = 0;

   alu_exec #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on the first cycle of each output, then checks hold and idle return
   logic         seen = 1'b0;
   logic         idle_chk = 1'b0;
   logic [W-1:0] held;
   exp_t         cur;

   always @(negedge clk) begin
      if (idle_chk) begin
         idle_chk = 1'b0;
         check("idle_after_handshake", 32'(in_ready), 32'd1);
      end
      if (rst_n && out_valid) begin
         if (!seen) begin
            seen = 1'b1;
            held = result;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid: got 0x%0h expected no output", result);
            end else begin
               cur = sb.pop_front();
               check({cur.tag, "_result"}, 32'(result), 32'(cur.res));
               check({cur.tag, "_latency"}, 32'(cyc - cur.acc), 32'(cur.wt));
            end
         end else begin
            check("hold_stable", 32'(result), 32'(held));
         end
         if (out_ready) begin
            seen = 1'b0;
            handshakes++;
            idle_chk = 1'b1;
         end
      end else begin
         seen = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic [W-1:0] r, input int wt, input bit push);
      int n = 0;
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_ready_timeout: got in_ready=0 expected 1", tag);
      end else begin
         in_valid = 1'b1;
         op = o;
         a = aa;
         b = bb;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (push) sb.push_back('{tag, r, wt, cyc});
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(in_ready && sb.size() == 0 && !out_valid) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got pending=%0d expected 0", sb.size());
      end
   endtask

   int hs_before;

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      op = 4'h0;
      a = '0;
      b = '0;
      out_ready = 1'b1;

      repeat (2) step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors: tag, op, a, b, expected result, cycles from accept to out_valid
      issue("add",      4'h4, 16'h7FFF, 16'h0001, 16'h8000, 0,  1);
      issue("rol4",     4'h0, 16'h8001, 16'h0004, 16'h0018, 4,  1);
      issue("srl15",    4'h3, 16'hF000, 16'h000F, 16'h0001, 15, 1);
      issue("sll0",     4'h1, 16'h1234, 16'h0000, 16'h1234, 0,  1);
      issue("slt",      4'h9, 16'hFFFF, 16'h0001, 16'h0001, 0,  1);
      issue("sco",      4'hB, 16'hFFFF, 16'h0001, 16'h0001, 0,  1);
      issue("btr",      4'hC, 16'h0001, 16'h0000, 16'h8000, 0,  1);
      issue("sub",      4'h5, 16'h0003, 16'h0001, 16'hFFFE, 0,  1);
      issue("xor",      4'h6, 16'hF0F0, 16'h0FF0, 16'hFF00, 0,  1);
      issue("andn",     4'h7, 16'hFFFF, 16'h00FF, 16'hFF00, 0,  1);
      issue("seq",      4'h8, 16'h0005, 16'h0005, 16'h0001, 0,  1);
      issue("sle_eq",   4'hA, 16'h8000, 16'h8000, 16'h0001, 0,  1);
      issue("sle_gt",   4'hA, 16'h0001, 16'hFFFF, 16'h0000, 0,  1);
      issue("ror1",     4'h2, 16'h0001, 16'h0001, 16'h8000, 1,  1);
      issue("rol15",    4'h0, 16'h0001, 16'h000F, 16'h8000, 15, 1);
      issue("ror15",    4'h2, 16'h8000, 16'h000F, 16'h0001, 15, 1);
      issue("sll15",    4'h1, 16'h0001, 16'h000F, 16'h8000, 15, 1);
      issue("sll_hi_b", 4'h1, 16'h0003, 16'h0012, 16'h000C, 2,  1);
      issue("rsv_d",    4'hD, 16'hFFFF, 16'hFFFF, 16'h0000, 0,  1);
      issue("rsv_f",    4'hF, 16'h1234, 16'h5678, 16'h0000, 0,  1);
      wait_idle();

      // Backpressure: hold DONE for five cycles while in_valid toggles
      hs_before = handshakes;
      out_ready = 1'b0;
      issue("bp_add", 4'h4, 16'h0001, 16'h0002, 16'h0003, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         in_valid = (i % 2 == 0);
         op = 4'h4;
         a = 16'hFFFF;
         b = 16'hFFFF;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      step();
      check("bp_single_handshake", 32'(handshakes - hs_before), 32'd1);

      // Flush two cycles into a 10-step rotate
      issue("ror_flush", 4'h2, 16'h1234, 16'h000A, 16'h0000, 0, 0);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_in_ready", 32'(in_ready), 32'd1);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      issue("after_flush", 4'h2, 16'h0003, 16'h0001, 16'h8001, 1, 1);
      wait_idle();

      // Reset pulse in the middle of a shift
      issue("srl_reset", 4'h3, 16'hFF00, 16'h0008, 16'h0000, 0, 0);
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("midrst_release_ready", 32'(in_ready), 32'd1);
      issue("after_reset", 4'h4, 16'h0002, 16'h0003, 16'h0005, 0, 1);
      wait_idle();
      repeat (3) step();
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
